// File: rtl/timer_pkg.sv
// Shared types for the programmable timer/counter: counting modes and FSM states.
package timer_pkg;

  typedef enum logic [1:0] {
    UP_FREE     = 2'b00,
    DOWN_RELOAD = 2'b01,
    ONE_SHOT    = 2'b10,
    HOLD        = 2'b11
  } tmr_mode_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    EXPIRED = 2'b10
  } tmr_state_e;

endpackage

// File: rtl/presc_div.sv
// Prescaler: emits a tick every presc+1 enabled cycles; sync_clr restarts the division.
module presc_div #(
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               clr_b,
  input  logic               en,
  input  logic               sync_clr,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] r_prescCnt;

  assign tick = en & (r_prescCnt == presc);

  // A lowered presc below the current count is reached again by natural wrap-around.
  always_ff @(posedge clk) begin
    if (!clr_b) begin
      r_prescCnt <= '0;
    end else if (sync_clr) begin
      r_prescCnt <= '0;
    end else if (en) begin
      if (tick) r_prescCnt <= '0;
      else      r_prescCnt <= r_prescCnt + 1'b1;
    end
  end

endmodule

// File: rtl/prog_timer_counter.sv
// Parametrised timer/counter with up/down-reload/one-shot modes, parallel load,
// prescaler and a registered one-cycle terminal-count pulse.
module prog_timer_counter
  import timer_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               clr_b,
  input  logic               en,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic [1:0]         mode,
  input  logic [PRESC_W-1:0] presc,
  output logic [WIDTH-1:0]   count,
  output logic               tc,
  output logic               busy
);

  localparam logic [WIDTH-1:0] MaxCount = '1;

  tmr_state_e       r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_tc;
  logic             r_busy;
  logic             w_tick;
  logic             w_prescEn;
  tmr_mode_e        w_mode;

  assign w_mode    = tmr_mode_e'(mode);
  assign w_prescEn = en & (r_state == RUN);

  presc_div #(.PRESC_W(PRESC_W)) u_presc (
    .clk      (clk),
    .clr_b    (clr_b),
    .en       (w_prescEn),
    .sync_clr (load),
    .presc    (presc),
    .tick     (w_tick)
  );

  // Load beats a coincident tick; busy is kept in step with the next state.
  always_ff @(posedge clk) begin
    if (!clr_b) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_tc     <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      if (load) begin
        r_count  <= load_val;
        r_reload <= load_val;
        r_state  <= RUN;
        r_busy   <= 1'b1;
      end else if (r_state == RUN && w_tick) begin
        case (w_mode)
          UP_FREE: begin
            if (r_count == MaxCount) begin
              r_count <= '0;
              r_tc    <= 1'b1;
            end else begin
              r_count <= r_count + 1'b1;
            end
          end
          DOWN_RELOAD: begin
            if (r_count == '0) begin
              r_count <= r_reload;
              r_tc    <= 1'b1;
            end else begin
              r_count <= r_count - 1'b1;
            end
          end
          ONE_SHOT: begin
            if (r_count == '0) begin
              r_tc    <= 1'b1;
              r_state <= EXPIRED;
              r_busy  <= 1'b0;
            end else begin
              r_count <= r_count - 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign busy  = r_busy;

endmodule
